// File: rtl/mac_acc_ctrl_if.sv
// Operand, adder and result signals of the MAC accumulator controller.
// master = upstream driver plus adder stage, slave = mac_acc_ctrl.
interface mac_acc_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
);
  logic              start;
  logic [CNT_W-1:0]  len;
  logic              op_valid;
  logic              op_ready;
  logic [DATA_W-1:0] op_data;
  logic              op_sub;
  logic [DATA_W-1:0] add_a;
  logic [DATA_W-1:0] add_b;
  logic              add_s;
  logic [DATA_W-1:0] add_out;
  logic              add_carry;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic              res_ovf;
  logic              busy;

  modport master (
    output start, len, op_valid, op_data, op_sub, add_out, add_carry, res_ready,
    input  op_ready, add_a, add_b, add_s, res_valid, res_data, res_ovf, busy
  );

  modport slave (
    input  start, len, op_valid, op_data, op_sub, add_out, add_carry, res_ready,
    output op_ready, add_a, add_b, add_s, res_valid, res_data, res_ovf, busy
  );
endinterface

// File: rtl/mac_acc_ctrl.sv
// Length-counted accumulator driving the 8-bit add/sub stage; result on valid/ready.
// Optional MAC_ACC_SAT_EN: saturate toward the accumulator sign on signed overflow.
module mac_acc_ctrl #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  mac_acc_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t            state;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] next_acc;
  logic [CNT_W-1:0]  cnt;
  logic              ovf;
  logic              op_ready_q;
  logic              res_valid_q;
  logic              busy_q;
  logic              beat;

  assign beat = bus.op_valid & op_ready_q;

  always_comb begin
    next_acc = bus.add_out;
`ifdef MAC_ACC_SAT_EN
    // Overflow can only occur in the direction of acc's sign.
    if (bus.add_carry)
      next_acc = acc[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                               : {1'b0, {(DATA_W-1){1'b1}}};
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc         <= '0;
      cnt         <= '0;
      ovf         <= 1'b0;
      op_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            acc    <= '0;
            ovf    <= 1'b0;
            cnt    <= bus.len;
            busy_q <= 1'b1;
            if (bus.len != '0) begin
              state      <= ACCUM;
              op_ready_q <= 1'b1;
            end else begin
              state       <= DONE;
              res_valid_q <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (beat) begin
            acc <= next_acc;
            ovf <= ovf | bus.add_carry;
            cnt <= cnt - 1'b1;
            if (cnt == {{(CNT_W-1){1'b0}}, 1'b1}) begin
              state       <= DONE;
              op_ready_q  <= 1'b0;
              res_valid_q <= 1'b1;
            end
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            state       <= IDLE;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          op_ready_q  <= 1'b0;
          res_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.op_ready  = op_ready_q;
  assign bus.add_a     = acc;
  assign bus.add_b     = bus.op_data;
  assign bus.add_s     = bus.op_sub;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = acc;
  assign bus.res_ovf   = ovf;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mac_acc_ctrl.sv
// Randomized self-checking bench for mac_acc_ctrl with an integer reference model
// and a behavioural add/sub stage; honours MAC_ACC_SAT_EN when defined.
module tb_mac_acc_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mac_acc_ctrl_if #(.DATA_W(8), .CNT_W(8)) bus ();

  mac_acc_ctrl #(.DATA_W(8), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;
  int adder_sum;

  bit [7:0] q_data[$];
  bit       q_sub[$];
  bit       q_vpat[$];

  // Behavioural 8-bit signed add/sub stage with signed-overflow flag.
  always_comb begin
    adder_sum = bus.add_s ? (int'($signed(bus.add_a)) - int'($signed(bus.add_b)))
                          : (int'($signed(bus.add_a)) + int'($signed(bus.add_b)));
    bus.add_out   = adder_sum[7:0];
    bus.add_carry = (adder_sum > 127) || (adder_sum < -128);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_step(inout int acc, inout bit ovf,
                                     input bit [7:0] d, input bit sub);
    int s;
    logic [7:0] t;
    s = sub ? acc - int'($signed(d)) : acc + int'($signed(d));
    if (s > 127 || s < -128) begin
      ovf = 1'b1;
`ifdef MAC_ACC_SAT_EN
      s = (s > 127) ? 127 : -128;
`endif
    end
    t   = s[7:0];
    acc = int'($signed(t));
  endfunction

  // vmode: 0 op_valid held high, 1 pattern from q_vpat, 2 random
  task automatic run_txn(input string name, input int n, input int vmode, input int hold,
                         input int lit_data, input int lit_ovf);
    int acc = 0;
    bit ovf = 1'b0;
    int idx = 0;
    int cyc = 0;
    logic [7:0] a8;
    @(posedge clk); #1;
    bus.start    = 1'b1;
    bus.len      = n[7:0];
    bus.op_valid = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    while (idx < n && cyc < 500) begin
      bit v;
      case (vmode)
        0:       v = 1'b1;
        1:       v = (q_vpat.size() > 0) ? q_vpat.pop_front() : 1'b1;
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      bus.op_valid = v;
      bus.op_data  = q_data[idx];
      bus.op_sub   = q_sub[idx];
      bus.start    = ($urandom_range(0, 4) == 0);
      bus.len      = 8'($urandom);
      @(negedge clk);
      a8 = acc[7:0];
      check({name, "_op_ready"}, bus.op_ready, 1);
      check({name, "_add_a"}, bus.add_a, a8);
      check({name, "_add_b"}, bus.add_b, q_data[idx]);
      check({name, "_add_s"}, bus.add_s, q_sub[idx]);
      check({name, "_early_valid"}, bus.res_valid, 0);
      @(posedge clk); #1;
      if (v) begin
        model_step(acc, ovf, q_data[idx], q_sub[idx]);
        idx++;
      end
      cyc++;
    end
    if (idx < n) check({name, "_timeout"}, idx, n);
    bus.op_valid = 1'b0;
    bus.start    = 1'b0;
    @(negedge clk);
    a8 = acc[7:0];
    check({name, "_res_valid"}, bus.res_valid, 1);
    check({name, "_res_data"}, bus.res_data, a8);
    check({name, "_res_ovf"}, bus.res_ovf, ovf);
    check({name, "_busy_done"}, bus.busy, 1);
    check({name, "_ready_done"}, bus.op_ready, 0);
    if (lit_data >= 0) begin
      check({name, "_lit_data"}, bus.res_data, lit_data);
      check({name, "_lit_ovf"}, bus.res_ovf, lit_ovf);
    end
    repeat (hold) begin
      @(negedge clk);
      check({name, "_hold_valid"}, bus.res_valid, 1);
      check({name, "_hold_data"}, bus.res_data, a8);
      check({name, "_hold_ovf"}, bus.res_ovf, ovf);
    end
    bus.res_ready = 1'b1;
    bus.start     = 1'b1;
    bus.len       = 8'd5;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    bus.start     = 1'b0;
    @(negedge clk);
    check({name, "_idle_valid"}, bus.res_valid, 0);
    check({name, "_idle_busy"}, bus.busy, 0);
    check({name, "_idle_ready"}, bus.op_ready, 0);
    @(negedge clk);
    check({name, "_start_ignored"}, bus.busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.start = 1'b0; bus.len = '0; bus.op_valid = 1'b0; bus.op_data = '0;
    bus.op_sub = 1'b0; bus.res_ready = 1'b0;

    #12;
    check("rst_op_ready", bus.op_ready, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_res_data", bus.res_data, 0);
    check("rst_res_ovf", bus.res_ovf, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_add_a", bus.add_a, 0);
    @(negedge clk);
    rst_n = 1'b1;

    q_data = '{8'd10, 8'd20, 8'd5}; q_sub = '{1'b0, 1'b0, 1'b1};
    run_txn("t1", 3, 0, 0, 8'h19, 0);

    q_data = '{8'd100, 8'd100}; q_sub = '{1'b0, 1'b0};
`ifdef MAC_ACC_SAT_EN
    run_txn("t2", 2, 0, 1, 8'h7F, 1);
`else
    run_txn("t2", 2, 0, 1, 8'hC8, 1);
`endif

    q_data = '{8'd100, 8'd100}; q_sub = '{1'b1, 1'b1};
`ifdef MAC_ACC_SAT_EN
    run_txn("t3", 2, 0, 0, 8'h80, 1);
`else
    run_txn("t3", 2, 0, 0, 8'h38, 1);
`endif

    q_data.delete(); q_sub.delete();
    run_txn("t4", 0, 0, 5, 0, 0);

    q_data = '{8'd1, 8'd1, 8'd1, 8'd1}; q_sub = '{1'b0, 1'b0, 1'b0, 1'b0};
    q_vpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    run_txn("t5", 4, 1, 2, 4, 0);
    check("t5_pattern_used", q_vpat.size(), 0);

    // Reset between clock edges in the middle of an accumulation.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.len = 8'd3;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.op_valid = 1'b1; bus.op_data = 8'd7; bus.op_sub = 1'b0;
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    @(negedge clk);
    check("t6_add_a_mid", bus.add_a, 7);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_op_ready", bus.op_ready, 0);
    check("t6_rst_busy", bus.busy, 0);
    check("t6_rst_add_a", bus.add_a, 0);
    check("t6_rst_res_valid", bus.res_valid, 0);
    check("t6_rst_res_data", bus.res_data, 0);
    check("t6_rst_res_ovf", bus.res_ovf, 0);
    @(negedge clk);
    check("t6_rst_hold_valid", bus.res_valid, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_post_busy", bus.busy, 0);
    check("t6_post_valid", bus.res_valid, 0);
    q_data = '{8'd3}; q_sub = '{1'b0};
    run_txn("t6b", 1, 0, 0, 3, 0);

    repeat (40) begin
      n = $urandom_range(0, 12);
      q_data.delete(); q_sub.delete();
      for (int i = 0; i < n; i++) begin
        q_data.push_back(8'($urandom));
        q_sub.push_back(1'($urandom));
      end
      run_txn("rnd", n, 2, $urandom_range(0, 3), -1, 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
